// File: rtl/rs_pkg.sv
// rs_pkg: GF(2^8) field constants, RS(255,239) generator taps and encoder states.
package rs_pkg;
   localparam int N = 255;
   localparam int NPAR = 16;
   localparam int K = N - NPAR;
   localparam int SYMW = 8;
   localparam logic [SYMW:0] POLY = 9'h11D;
   // g(x) = prod_{i=0..15} (x + alpha^i); G[i] is the x^i coefficient, x^16 is implicit
   localparam logic [SYMW-1:0] G [0:NPAR-1] = '{
      8'h3b, 8'h24, 8'h32, 8'h62, 8'he5, 8'h29, 8'h41, 8'ha3,
      8'h08, 8'h1e, 8'hd1, 8'h44, 8'hbd, 8'h68, 8'h0d, 8'h3b
   };
   typedef enum logic [1:0] {IDLE, MSG, PAR} state_e;
   function automatic logic [SYMW-1:0] gf_mul(input logic [SYMW-1:0] a, input logic [SYMW-1:0] b);
      logic [SYMW-1:0] p, x;
      p = '0;
      x = a;
      for (int k = 0; k < SYMW; k++) begin
         p = b[k] ? p ^ x : p;
         x = x[SYMW-1] ? (x << 1) ^ POLY[SYMW-1:0] : x << 1;
      end
      return p;
   endfunction
endpackage

// File: rtl/gf_const_mul.sv
// gf_const_mul: multiply a symbol by a fixed GF(2^8) constant as a pure XOR network.
module gf_const_mul
   import rs_pkg::*;
#(
   parameter logic [SYMW-1:0] C = 8'h01
) (
   input  logic [SYMW-1:0] a_i,
   output logic [SYMW-1:0] y_o
);
   logic [SYMW-1:0] col [SYMW];
   // each input bit selects the constant column C*alpha^i
   for (genvar i = 0; i < SYMW; i++) begin : g_col
      localparam logic [SYMW-1:0] P = gf_mul(C, SYMW'(1 << i));
      assign col[i] = a_i[i] ? P : '0;
   end
   always_comb begin
      y_o = '0;
      for (int j = 0; j < SYMW; j++) y_o ^= col[j];
   end
endmodule

// File: rtl/rs_encoder.sv
// rs_encoder: systematic RS(255,239) encoder, message passthrough then 16 LFSR parity symbols.
// Optional RS_ENC_SHORT_EN adds msg_len for shortened codewords (zero-prefixed parity).
module rs_encoder
   import rs_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [SYMW-1:0] din,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SYMW-1:0] dout,
   output logic            out_sop,
   output logic            out_eop,
`ifdef RS_ENC_SHORT_EN
   input  logic [SYMW-1:0] msg_len,
`endif
   output logic            busy
);
   state_e state_q, state_d;
   logic [SYMW-1:0] cnt_q, cnt_d;
   logic [SYMW-1:0] r_q [NPAR];
   logic [SYMW-1:0] r_d [NPAR];
   logic [SYMW-1:0] gm [NPAR];
   logic [SYMW-1:0] dout_q, dout_d, fb, in_len, cur_len;
   logic valid_q, valid_d, sop_q, sop_d, eop_q, eop_d, adv, acc, last;
`ifdef RS_ENC_SHORT_EN
   logic [SYMW-1:0] len_q, len_d;
   assign in_len = (msg_len == '0 || msg_len > SYMW'(K)) ? SYMW'(K) : msg_len;
   assign cur_len = len_q;
   assign len_d = (state_q == IDLE && acc) ? in_len : len_q;
   always_ff @(posedge clk) len_q <= reset ? '0 : len_d;
`else
   assign in_len = SYMW'(K);
   assign cur_len = SYMW'(K);
`endif
   assign adv = out_ready | ~valid_q;
   assign in_ready = adv & (state_q != PAR);
   assign acc = in_valid & in_ready;
   assign fb = din ^ r_q[NPAR-1];
   assign last = cnt_q + 1'b1 == (state_q == IDLE ? in_len : cur_len);
   for (genvar i = 0; i < NPAR; i++) begin : g_tap
      gf_const_mul #(.C(G[i])) u_mul (.a_i(fb), .y_o(gm[i]));
   end
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      r_d = r_q;
      dout_d = dout_q;
      valid_d = valid_q;
      sop_d = sop_q;
      eop_d = eop_q;
      if (adv && state_q == PAR) begin
         valid_d = 1'b1;
         dout_d = r_q[NPAR-1];
         r_d[0] = '0;
         for (int j = 1; j < NPAR; j++) r_d[j] = r_q[j-1];
         sop_d = 1'b0;
         eop_d = cnt_q == SYMW'(NPAR-1);
         cnt_d = eop_d ? '0 : cnt_q + 1'b1;
         state_d = eop_d ? IDLE : PAR;
      end else if (adv) begin
         valid_d = acc;
         sop_d = acc & (state_q == IDLE);
         eop_d = 1'b0;
         if (acc) begin
            dout_d = din;
            r_d[0] = gm[0];
            for (int j = 1; j < NPAR; j++) r_d[j] = r_q[j-1] ^ gm[j];
            cnt_d = last ? '0 : cnt_q + 1'b1;
            state_d = last ? PAR : MSG;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q <= '0;
         r_q <= '{default: '0};
         dout_q <= '0;
         valid_q <= 1'b0;
         sop_q <= 1'b0;
         eop_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         r_q <= r_d;
         dout_q <= dout_d;
         valid_q <= valid_d;
         sop_q <= sop_d;
         eop_q <= eop_d;
      end
   end
   assign out_valid = valid_q;
   assign dout = dout_q;
   assign out_sop = sop_q;
   assign out_eop = eop_q;
   assign busy = state_q != IDLE;
endmodule
